// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
//
// Purpose: FSM state encoding, port count, default widths and the command
//          record latched when a request is accepted.
package dmem_arb_pkg;

  localparam int NUM_PORTS   = 2;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 32;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

  typedef struct packed {
    logic                   port;     // owning requester (0 or 1)
    logic                   write;    // 1 = store, 0 = load
    logic [DMEM_ADDR_W-1:0] address;  // byte address as presented
    logic [DMEM_DATA_W-1:0] data;     // store data
  } dmem_cmd_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - combinational two-port grant selection
//
// Purpose: one-hot grant from the two request valids. A port is granted only
//          when its valid is high.
// Config : DMEM_ARB_ROUND_ROBIN_EN defined   -> on a tie the port not granted
//                                               last wins.
//          DMEM_ARB_ROUND_ROBIN_EN undefined -> port 0 always wins a tie.
// Ports  : valid_i      in  [NUM_PORTS-1:0] request valids, bit n = port n
//          last_grant_i in  1               port granted at the last acceptance
//          grant_o      out [NUM_PORTS-1:0] one-hot grant (or zero)
import dmem_arb_pkg::*;

module dmem_rr_pick (
  input  logic [NUM_PORTS-1:0] valid_i,
  input  logic                 last_grant_i,
  output logic [NUM_PORTS-1:0] grant_o
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_o = '0;
    if (valid_i[0] && valid_i[1]) begin
      // Tie: favour whichever port did not win last time.
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end else if (valid_i[0]) begin
      grant_o = 2'b01;
    end else if (valid_i[1]) begin
      grant_o = 2'b10;
    end
  end
`else
  // History is irrelevant under fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign grant_o = {valid_i[1] & ~valid_i[0], valid_i[0]};
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and access sequencer for data memory
//
// Purpose: shares one DataMemory between port 0 (CPU) and port 1 (loader).
//          Each access runs IDLE (accept) -> ACCESS (memory cycle) -> RESP
//          (completion strobe). Load data is registered per port.
// Config : DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration in
//          dmem_rr_pick; default is fixed priority to port 0.
// Ports  : clk, rst                 clock, synchronous active-high reset
//          ReqValid/Write/Address/WriteData0/1  request side, per port
//          ReqReady0/1              acceptance this cycle (IDLE winner only)
//          RspValid0/1, RspData0/1  one-cycle completion strobe, load data
//          Address, WriteData, MemWrite, MemRead, Startin  to memory
//          ReadData                 from memory, combinational read
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int DATA_WIDTH = DMEM_DATA_W,
  parameter int ADDR_WIDTH = DMEM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ReqValid0,
  input  logic                  ReqWrite0,
  input  logic [ADDR_WIDTH-1:0] ReqAddress0,
  input  logic [DATA_WIDTH-1:0] ReqWriteData0,
  output logic                  ReqReady0,
  output logic                  RspValid0,
  output logic [DATA_WIDTH-1:0] RspData0,
  input  logic                  ReqValid1,
  input  logic                  ReqWrite1,
  input  logic [ADDR_WIDTH-1:0] ReqAddress1,
  input  logic [DATA_WIDTH-1:0] ReqWriteData1,
  output logic                  ReqReady1,
  output logic                  RspValid1,
  output logic [DATA_WIDTH-1:0] RspData1,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic                  Startin,
  input  logic [DATA_WIDTH-1:0] ReadData
);

  dmem_state_e           state_q, state_d;
  dmem_cmd_t             cmd_q, cmd_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] rsp_data0_q, rsp_data0_d;
  logic [DATA_WIDTH-1:0] rsp_data1_q, rsp_data1_d;
  logic [NUM_PORTS-1:0]  grant;

  dmem_rr_pick u_pick (
    .valid_i      ({ReqValid1, ReqValid0}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      cmd_q        <= '0;
      last_grant_q <= 1'b1;  // port 0 wins the first tie
      rsp_data0_q  <= '0;
      rsp_data1_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      last_grant_q <= last_grant_d;
      rsp_data0_q  <= rsp_data0_d;
      rsp_data1_q  <= rsp_data1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    last_grant_d = last_grant_q;
    rsp_data0_d  = rsp_data0_q;
    rsp_data1_d  = rsp_data1_q;
    ReqReady0    = 1'b0;
    ReqReady1    = 1'b0;
    unique case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        ReqReady0 = grant[0] & ~rst;
        ReqReady1 = grant[1] & ~rst;
        // A grant implies the winner's valid is high, so it is the handshake.
        if (|grant) begin
          cmd_d.port    = grant[1];
          cmd_d.write   = grant[1] ? ReqWrite1     : ReqWrite0;
          cmd_d.address = grant[1] ? ReqAddress1   : ReqAddress0;
          cmd_d.data    = grant[1] ? ReqWriteData1 : ReqWriteData0;
          last_grant_d  = grant[1];
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        if (!cmd_q.write) begin
          if (cmd_q.port) rsp_data1_d = ReadData;
          else            rsp_data0_d = ReadData;
        end
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Memory-side controls are gated by rst in the same cycle so an access
  // interrupted by reset never reaches the array.
  assign MemWrite  = (state_q == ACCESS) &  cmd_q.write & ~rst;
  assign MemRead   = (state_q == ACCESS) & ~cmd_q.write & ~rst;
  assign Address   = {cmd_q.address[ADDR_WIDTH-1:2], 2'b00};
  assign WriteData = cmd_q.data;
  assign Startin   = (state_q == INIT) | rst;

  assign RspValid0 = (state_q == RESP) & ~cmd_q.port & ~rst;
  assign RspValid1 = (state_q == RESP) &  cmd_q.port & ~rst;
  assign RspData0  = rsp_data0_q;
  assign RspData1  = rsp_data1_q;

  // Byte offset is kept in the command but the memory is word-addressed.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_q.address[1:0];

endmodule
